// File: rtl/fetch_sequencer_if.sv
// Instruction BRAM read port between the fetch sequencer (master) and the memory (slave).
interface fetch_sequencer_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;

  modport master (output mem_en, output mem_addr, input mem_dout);
  modport slave  (input mem_en, input mem_addr, output mem_dout);
endinterface

// File: rtl/fetch_sequencer.sv
// Single-clock instruction fetch sequencer: one BRAM read per run tick or step edge,
// captures the returned word and advances the PC.
module fetch_sequencer #(
  parameter int unsigned DIV_MAX   = 50_000_000,
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned PC_STEP   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode_run,
  input  logic                step,
  input  logic                halt_req,
  fetch_sequencer_if.master   bus,
  output logic [31:0]         pc,
  output logic [31:0]         inst,
  output logic                inst_valid,
  output logic                halted,
  output logic [15:0]         inst_count,
  output logic [1:0]          state
);

  localparam int unsigned DIV_W  = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned PC_MOD = MEM_WORDS * 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_CAPTURE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [DIV_W-1:0]   r_div;
  logic               r_step_prev;
  logic [31:0]        r_pc;
  logic [31:0]        r_inst;
  logic               r_inst_valid;
  logic               r_mem_en;
  logic               r_halted;
  logic [CNT_W-1:0]   r_inst_count;

  logic               w_step_edge;
  logic               w_div_run;
  logic               w_tick;
  logic               w_trigger;
  logic [31:0]        w_pc_next;

  assign w_step_edge = step & ~r_step_prev;
  assign w_div_run   = mode_run & (r_state != S_HALT);
  assign w_tick      = w_div_run & (r_div == DIV_W'(DIV_MAX - 1));
  assign w_trigger   = mode_run ? w_tick : w_step_edge;
  assign w_pc_next   = 32'((64'(r_pc) + 64'(PC_STEP)) % 64'(PC_MOD));

  // Rate divider: frozen in HALT, cleared whenever single-step mode is selected.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div <= '0;
    end else if (!mode_run) begin
      r_div <= '0;
    end else if (r_state != S_HALT) begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (halt_req)       w_state_next = S_HALT;
        else if (w_trigger) w_state_next = S_READ;
      end
      S_READ:    w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = halt_req ? S_HALT : S_IDLE;
      S_HALT: begin
        if (w_step_edge && !halt_req) w_state_next = S_IDLE;
      end
      default:   w_state_next = S_IDLE;
    endcase
  end

  // State and registered outputs; mem_en/halted are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_step_prev  <= 1'b1;
      r_pc         <= '0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_mem_en     <= 1'b0;
      r_halted     <= 1'b0;
      r_inst_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_step_prev  <= step;
      r_mem_en     <= (w_state_next == S_READ);
      r_halted     <= (w_state_next == S_HALT);
      r_inst_valid <= 1'b0;
      if (r_state == S_CAPTURE) begin
        r_inst       <= bus.mem_dout;
        r_inst_valid <= 1'b1;
        r_pc         <= w_pc_next;
        if (r_inst_count != {CNT_W{1'b1}}) r_inst_count <= r_inst_count + CNT_W'(1);
      end
    end
  end

  assign bus.mem_en   = r_mem_en;
  assign bus.mem_addr = r_pc;
  assign pc           = r_pc;
  assign inst         = r_inst;
  assign inst_valid   = r_inst_valid;
  assign halted       = r_halted;
  assign inst_count   = r_inst_count;
  assign state        = r_state;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer sitting between the board clock domain and the instruction BRAM. It replaces the free-running divided-clock PC with a single-clock FSM. The FSM issues one BRAM read per trigger, captures the returned word, and advances the PC. A trigger is either an internal rate tick (run mode) or a step-button edge (step mode). Its `inst`/`inst_valid` outputs feed the main decoder and the seven-segment display.

## Interface
- `DIV_MAX`, 50_000_000: core cycles between run-mode triggers; must be ≥ 4.
- `MEM_WORDS`, 64: instruction BRAM depth in 32-bit words; PC wraps modulo `MEM_WORDS*4`.
- `PC_STEP`, 4: PC increment in bytes per fetched instruction.

- `clk`  in  1  core clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `mode_run`  in  1  1 = free-run at the `DIV_MAX` rate; 0 = single-step.
- `step`  in  1  debounced step button (level); the block edge-detects it internally.
- `halt_req`  in  1  request to stop fetching (level).
- `mem_dout`  in  32  BRAM read data; valid one cycle after `mem_en` is sampled.
- `mem_en`  out  1  BRAM enable.
- `mem_addr`  out  32  BRAM byte address; always equal to `pc`.
- `pc`  out  32  address of the next instruction to fetch.
- `inst`  out  32  last captured instruction (registered).
- `inst_valid`  out  1  one-cycle pulse when `inst` updates.
- `halted`  out  1  high while in HALT.
- `inst_count`  out  16  instructions captured since reset; saturates at 16'hFFFF.
- `state`  out  2  FSM encoding for debug: IDLE = 0, READ = 1, CAPTURE = 2, HALT = 3.

## Operation
- **Reset** (`rst` = 0 at a rising edge): the following are all set.
  - State: IDLE.
  - Outputs: `pc` = 0, `inst` = 0, `inst_valid` = 0, `mem_en` = 0, `halted` = 0, `inst_count` = 0.
  - Internals: divider counter = 0, `step_prev` = 1 (so a button held through reset produces no step).
- **Trigger sources:**
  - Run mode:
    - The divider counts 0..`DIV_MAX`-1 while `mode_run` = 1 and the state is not HALT.
    - Tick = counter equals `DIV_MAX`-1; the counter then returns to 0.
    - The counter is cleared whenever `mode_run` = 0.
  - Step mode: trigger = `step` & ~`step_prev` while `mode_run` = 0; `step_prev` is registered every cycle.
  - Triggers arriving outside IDLE are dropped, not queued.
- **FSM transitions:**
  - IDLE → READ on trigger, when `halt_req` = 0.
  - IDLE → HALT when `halt_req` = 1; `halt_req` takes priority over a same-cycle trigger.
  - READ → CAPTURE unconditionally. `mem_en` = 1 during READ only.
  - CAPTURE → IDLE, or → HALT if `halt_req` = 1. An in-flight fetch always completes. On the CAPTURE exit edge:
    - `inst` ← `mem_dout`
    - `inst_valid` ← 1
    - `pc` ← (`pc` + `PC_STEP`) mod (`MEM_WORDS`*4)
    - `inst_count` ← `inst_count` + 1, saturating
  - HALT → IDLE on a step rising edge with `halt_req` = 0, in either mode. The resume edge does not itself start a fetch.
- **`inst_valid`** is cleared on every edge where it was not just set, so it is exactly one cycle wide.
- **`halted`** is registered and equals (next state == HALT).
- **Mid-operation reset:** a reset asserted during READ or CAPTURE aborts the fetch. `inst` is not updated and `inst_valid` does not pulse.
- **Mode changes:**
  - `mode_run` toggling during READ or CAPTURE does not affect the in-flight fetch.
  - `step` edges while `mode_run` = 1 are ignored, except in HALT.

## Timing
- Trigger sampled at edge E0: READ for the cycle after E0, with `mem_en` = 1 and `mem_addr` = `pc`.
- BRAM samples the address at E1; CAPTURE for the cycle after E1, with `mem_dout` valid.
- E2: `inst`, `inst_valid`, `pc` and `inst_count` update; the state returns to IDLE.
- Trigger-to-`inst_valid` latency is 2 cycles; fetch occupancy is 3 cycles including IDLE.
- Run-mode trigger period is exactly `DIV_MAX` cycles. The first tick after reset, or after run mode is entered, comes `DIV_MAX` cycles later.
- `mem_addr` is stable throughout READ and CAPTURE.

## Test plan
- **Reset values:** hold `rst` = 0 for 3 cycles with `step` = 1, then release. Required:
  - all outputs at their reset values;
  - no fetch occurs, because `step_prev` = 1 suppresses a spurious edge.
- **Single step:** `mode_run` = 0, BRAM preloaded with word i = 32'h1000_0000 + i; pulse `step` 3 times, spaced ≥ 5 cycles. Required:
  - each `inst_valid` pulse comes 2 cycles after the sampled edge and is 1 cycle wide;
  - `inst` = 10000000, 10000001, 10000002;
  - `pc` = 4, 8, 12; `inst_count` = 3.
- **Run mode:** `DIV_MAX` = 8, `mode_run` = 1 for 40 cycles. Required:
  - `inst_valid` pulses exactly every 8 cycles, the first at cycle 10 after `mode_run` rises;
  - `mem_en` is high for exactly 1 cycle per fetch.
- **Wrap-around:** `MEM_WORDS` = 4, 5 steps. Required: `pc` sequence 4, 8, 12, 0, 4; the fifth `inst` equals word 0.
- **Halt and resume:** raise `halt_req` during READ. Required:
  - the fetch completes with `inst_valid` pulsing;
  - HALT follows, with `halted` = 1;
  - run ticks are ignored while halted.
  Then drop `halt_req` and pulse `step`. Required: IDLE with no fetch; the next step fetches normally.
- **Reset mid-fetch:** assert `rst` = 0 during CAPTURE. Required:
  - `inst` stays 0 and `inst_valid` never pulses;
  - `pc` = 0 and the state is IDLE on the next cycle.
